// File: rtl/cond_flags_unit.sv
// cond_flags_unit: architectural NZCV flag register, one-deep saved-flags
// shadow for exception entry/return, and conditional gating of the
// PCSrc/RegWrite/MemWrite write strobes.
// Optional feature: define COND_SKIP_COUNT_EN to add a saturating counter of
// squashed instructions (SkipCount, cleared by SkipClr, width SKIP_W).
module cond_flags_unit
`ifdef COND_SKIP_COUNT_EN
#(
    parameter int SKIP_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Stall,
    input  logic       CondEx,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       ExcEntry,
    input  logic       ExcReturn,
    output logic [3:0] Flags,
    output logic [3:0] SavedFlags,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Squash
`ifdef COND_SKIP_COUNT_EN
    ,
    input  logic              SkipClr,
    output logic [SKIP_W-1:0] SkipCount
`endif
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] saved_q;
    logic [3:0] saved_d;

    // Only a clean 1 counts as a condition pass; X or 0 both fail.
    logic cond_pass;
    assign cond_pass = (CondEx === 1'b1);

    // An instruction is live when not in reset, not stalled and not
    // displaced by an exception being taken this cycle.
    logic act;
    assign act = ~reset & ~Stall & ~ExcEntry;

    // Per-half flag write enables: half 1 covers N,Z and half 0 covers C,V.
    logic [1:0] half_we;
    logic [3:0] half_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_we[gi]             = FlagW[gi] & cond_pass;
            assign half_mask[2*gi +: 2]    = {2{half_we[gi]}};
        end
    endgenerate

    // Zero-latency gated strobes; an exception return always redirects the
    // PC and suppresses any register or memory write.
    always_comb begin
        PCSrc    = act & (ExcReturn | (PCS & cond_pass));
        RegWrite = act & ~ExcReturn & RegW & ~NoWrite & cond_pass;
        MemWrite = act & ~ExcReturn & MemW & cond_pass;
        Squash   = act & ~ExcReturn & ~cond_pass;
    end

    // Next flag/shadow state: stall holds, entry saves the pre-update flags,
    // return restores them, otherwise each half updates independently.
    always_comb begin
        flags_d = flags_q;
        saved_d = saved_q;
        if (!Stall) begin
            if (ExcEntry) begin
                saved_d = flags_q;
            end else if (ExcReturn) begin
                flags_d = saved_q;
            end else begin
                flags_d = (flags_q & ~half_mask) | (ALUFlags & half_mask);
            end
        end
    end

    // Flag and shadow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            saved_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
            saved_q <= saved_d;
        end
    end

    assign Flags      = flags_q;
    assign SavedFlags = saved_q;

`ifdef COND_SKIP_COUNT_EN
    logic [SKIP_W-1:0] skip_q;
    logic [SKIP_W-1:0] skip_d;

    // Squash counter: clear beats increment, saturates at all-ones, and
    // holds during a stall.
    always_comb begin
        skip_d = skip_q;
        if (!Stall) begin
            if (SkipClr) begin
                skip_d = '0;
            end else if (Squash && (skip_q != {SKIP_W{1'b1}})) begin
                skip_d = skip_q + SKIP_W'(1);
            end
        end
    end

    // Squash counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q <= '0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign SkipCount = skip_q;
`endif

endmodule

// File: tb/tb_cond_flags_unit.sv
// Testbench for cond_flags_unit: directed sequences with literal expectations
// followed by randomized traffic checked every cycle against a flag model.
module tb_cond_flags_unit;

    logic       clk;
    logic       reset;
    logic       Stall;
    logic       CondEx;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       ExcEntry;
    logic       ExcReturn;
    logic [3:0] Flags;
    logic [3:0] SavedFlags;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       Squash;
`ifdef COND_SKIP_COUNT_EN
    logic       SkipClr;
    logic [3:0] SkipCount;
    int         m_skip;
`endif

    int checks;
    int failures;

    // Model state
    logic [3:0] m_flags;
    logic [3:0] m_saved;

`ifdef COND_SKIP_COUNT_EN
    cond_flags_unit #(.SKIP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .CondEx     (CondEx),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .ExcEntry   (ExcEntry),
        .ExcReturn  (ExcReturn),
        .Flags      (Flags),
        .SavedFlags (SavedFlags),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Squash     (Squash),
        .SkipClr    (SkipClr),
        .SkipCount  (SkipCount)
    );
`else
    cond_flags_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .CondEx     (CondEx),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .ExcEntry   (ExcEntry),
        .ExcReturn  (ExcReturn),
        .Flags      (Flags),
        .SavedFlags (SavedFlags),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Squash     (Squash)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
        end
    endtask

    // Model update at each rising edge, straight from the flag rules.
    always @(posedge clk) begin
        logic [3:0] mask;
        mask = {{2{FlagW[1] & CondEx}}, {2{FlagW[0] & CondEx}}};
        if (reset) begin
            m_flags = 4'h0;
            m_saved = 4'h0;
`ifdef COND_SKIP_COUNT_EN
            m_skip  = 0;
`endif
        end else if (!Stall) begin
`ifdef COND_SKIP_COUNT_EN
            if (SkipClr) m_skip = 0;
            else if (!ExcEntry && !ExcReturn && !CondEx && m_skip < 15) m_skip = m_skip + 1;
`endif
            if (ExcEntry)       m_saved = m_flags;
            else if (ExcReturn) m_flags = m_saved;
            else                m_flags = (m_flags & ~mask) | (ALUFlags & mask);
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        logic live;
        live = !reset && !Stall && !ExcEntry;
        chk("flags",    {12'h0, Flags},      {12'h0, m_flags});
        chk("saved",    {12'h0, SavedFlags}, {12'h0, m_saved});
        chk("pcsrc",    {15'h0, PCSrc},    {15'h0, live && (ExcReturn || (PCS && CondEx))});
        chk("regwrite", {15'h0, RegWrite}, {15'h0, live && !ExcReturn && RegW && !NoWrite && CondEx});
        chk("memwrite", {15'h0, MemWrite}, {15'h0, live && !ExcReturn && MemW && CondEx});
        chk("squash",   {15'h0, Squash},   {15'h0, live && !ExcReturn && !CondEx});
`ifdef COND_SKIP_COUNT_EN
        chk("skipcount", {12'h0, SkipCount}, 16'(m_skip));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; Stall = 1'b0; CondEx = 1'b0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        ExcEntry = 1'b0; ExcReturn = 1'b0;
`ifdef COND_SKIP_COUNT_EN
        SkipClr = 1'b0;
`endif
    endtask

    task automatic set_flags(input logic [3:0] v);
        idle();
        CondEx = 1'b1; FlagW = 2'b11; ALUFlags = v;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_flags = 4'h0;
        m_saved = 4'h0;
`ifdef COND_SKIP_COUNT_EN
        m_skip = 0;
`endif
        idle();
        reset = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; CondEx = 1'b1;
        tick(); tick();
        chk("rst_flags",  {12'h0, Flags},      16'h0000);
        chk("rst_saved",  {12'h0, SavedFlags}, 16'h0000);
        chk("rst_strobe", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h0000);

        // Flag write lands only after the edge
        idle(); CondEx = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1010;
        #1 chk("t1_before", {12'h0, Flags}, 16'h0000);
        tick();
        chk("t1_after", {12'h0, Flags}, 16'h000a);
        chk("t1_model", {12'h0, m_flags}, 16'h000a);
        reset = 1'b1; tick();
        chk("t1_reset_flags", {12'h0, Flags}, 16'h0000);
        chk("t1_reset_saved", {12'h0, SavedFlags}, 16'h0000);

        // Independent halves
        idle(); CondEx = 1'b1; FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        chk("t2_nz", {12'h0, Flags}, 16'h000c);
        FlagW = 2'b01; ALUFlags = 4'b0001;
        tick();
        chk("t2_cv", {12'h0, Flags}, 16'h000d);
        chk("t2_model", {12'h0, m_flags}, 16'h000d);

        // Condition fail squashes everything
        idle(); RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
        #1 chk("t3_squash", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h0001);
        tick();
        chk("t3_hold", {12'h0, Flags}, 16'h000d);
        CondEx = 1'b1; NoWrite = 1'b1; FlagW = 2'b00;
        #1 chk("t3_nowrite", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h000a);
        tick();

        // Exception entry, return, and both together
        set_flags(4'b0110);
        idle(); ExcEntry = 1'b1; FlagW = 2'b11; CondEx = 1'b1; ALUFlags = 4'hf; RegW = 1'b1; PCS = 1'b1;
        #1 chk("t4_entry_strobe", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h0000);
        tick();
        chk("t4_entry_saved", {12'h0, SavedFlags}, 16'h0006);
        chk("t4_entry_flags", {12'h0, Flags}, 16'h0006);
        set_flags(4'b1001);
        idle(); ExcReturn = 1'b1; RegW = 1'b1; CondEx = 1'b1; FlagW = 2'b11;
        #1 chk("t4_ret_strobe", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h0008);
        tick();
        chk("t4_ret_flags", {12'h0, Flags}, 16'h0006);
        set_flags(4'b1001);
        idle(); ExcEntry = 1'b1; ExcReturn = 1'b1; CondEx = 1'b1;
        #1 chk("t4_both_pcsrc", {15'h0, PCSrc}, 16'h0000);
        tick();
        chk("t4_both_saved", {12'h0, SavedFlags}, 16'h0009);
        chk("t4_both_flags", {12'h0, Flags}, 16'h0009);

        // Stall freezes state and strobes
        set_flags(4'b0011);
        idle(); Stall = 1'b1; FlagW = 2'b11; CondEx = 1'b1; ExcReturn = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        #1 chk("t5_strobe", {12'h0, PCSrc, RegWrite, MemWrite, Squash}, 16'h0000);
        tick();
        chk("t5_flags", {12'h0, Flags}, 16'h0003);
        chk("t5_saved", {12'h0, SavedFlags}, 16'h0009);

`ifdef COND_SKIP_COUNT_EN
        idle(); reset = 1'b1; tick();
        idle();
        for (int i = 0; i < 20; i++) tick();
        chk("t6_sat", {12'h0, SkipCount}, 16'h000f);
        SkipClr = 1'b1;
        tick();
        chk("t6_clr", {12'h0, SkipCount}, 16'h0000);
`endif

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 40) == 0);
            Stall     = ($urandom_range(0, 7) == 0);
            CondEx    = $urandom_range(0, 1) == 1;
            ALUFlags  = 4'($urandom);
            FlagW     = 2'($urandom);
            PCS       = $urandom_range(0, 1) == 1;
            RegW      = $urandom_range(0, 1) == 1;
            MemW      = $urandom_range(0, 1) == 1;
            NoWrite   = ($urandom_range(0, 3) == 0);
            ExcEntry  = ($urandom_range(0, 9) == 0);
            ExcReturn = ($urandom_range(0, 9) == 0);
`ifdef COND_SKIP_COUNT_EN
            SkipClr   = ($urandom_range(0, 30) == 0);
`endif
            tick();
        end

        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
